pwm_fade_ramp: RTL and testbench

Upstream level generator for the 8-bit PWM stage. It produces the registered `level` byte that the PWM consumes and slews it smoothly instead of jumping.
- One-shot ramp mode: level moves one LSB per step toward a loaded target, then reports completion.
- Breathe mode: level runs a continuous triangle between 0 and a programmable peak.
- Step rate is set by a programmable clock prescaler.

---
 rtl/pwm_fade_ramp.sv | 78 +++++++
 tb/tb_pwm_fade_ramp.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ramp.sv
// pwm_fade_ramp: slews the PWM level one LSB per prescaled step, as a one-shot ramp or a continuous breathe triangle.
module pwm_fade_ramp #(
  parameter int RATE_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            target,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic                  load,
  input  logic                  breathe,
  output logic [7:0]            level,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, RAMP_UP, RAMP_DOWN, BR_UP, BR_DOWN} state_t;
  state_t state, state_n, toward;
  logic [7:0] target_r, target_n, level_n, stepped;
  logic [RATE_WIDTH-1:0] rate_r, rate_n, presc, presc_n;
  logic done_n, tick, up, ramp;
  assign tick = (state != IDLE) && (presc == rate_r - RATE_WIDTH'(1));
  assign ramp = (state == RAMP_UP) || (state == RAMP_DOWN);
  assign up = (state == RAMP_UP) || (state == BR_UP);
  assign stepped = up ? ((level == 8'hff) ? level : level + 8'd1)
                      : ((level == 8'd0) ? level : level - 8'd1);
  assign toward = (level < target_r) ? RAMP_UP : (level > target_r) ? RAMP_DOWN : IDLE;
  always_comb begin
    state_n = state;
    level_n = level;
    target_n = target_r;
    rate_n = rate_r;
    done_n = 1'b0;
    presc_n = (state == IDLE || tick) ? '0 : presc + RATE_WIDTH'(1);
    if (load) begin
      target_n = target;
      rate_n = (rate == '0) ? RATE_WIDTH'(1) : rate;
      presc_n = '0;
      state_n = breathe ? ((level < target) ? BR_UP : BR_DOWN)
              : (level < target) ? RAMP_UP : (level > target) ? RAMP_DOWN : IDLE;
      done_n = !breathe && (level == target);
    end else if (state == IDLE) begin
      if (breathe) state_n = (level < target_r) ? BR_UP : BR_DOWN;
    end else if (ramp) begin
      if (tick) level_n = stepped;
      if (breathe) state_n = (level_n < target_r) ? BR_UP : BR_DOWN;
      else if (tick && stepped == target_r) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
    end else if (!breathe) begin
      state_n = toward;
      done_n = (toward == IDLE);
    end else if (tick) begin
      // a zero peak parks the triangle at 0 in BR_DOWN instead of bouncing
      level_n = stepped;
      if (up && stepped >= target_r) state_n = BR_DOWN;
      else if (!up && stepped == 8'd0 && target_r != 8'd0) state_n = BR_UP;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      level <= 8'd0;
      busy <= 1'b0;
      done <= 1'b0;
      target_r <= 8'd0;
      rate_r <= RATE_WIDTH'(1);
      presc <= '0;
    end else begin
      state <= state_n;
      level <= level_n;
      busy <= (state_n != IDLE);
      done <= done_n;
      target_r <= target_n;
      rate_r <= rate_n;
      presc <= presc_n;
    end
  end
endmodule

// File: tb/tb_pwm_fade_ramp.sv
// tb_pwm_fade_ramp: directed scoreboard bench; expected level/done events are queued with their edge numbers.
module tb_pwm_fade_ramp;
  logic clock = 0, reset = 1, load = 0, breathe = 0;
  logic [7:0] target = 0, level, prev = 0;
  logic [15:0] rate = 0;
  logic busy, done;
  int cyc = 0, checks = 0, fails = 0, e0;
  bit mon_en = 0;
  typedef struct {int cyc; int val;} ev_t;
  ev_t lq[$], dq[$];

  pwm_fade_ramp #(.RATE_WIDTH(16)) dut (.clock(clock), .reset(reset), .target(target), .rate(rate),
    .load(load), .breathe(breathe), .level(level), .busy(busy), .done(done));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (level !== prev) begin
          checks++;
          if (lq.size() == 0) begin
            fails++;
            $display("FAIL level_event: got level=%0d at edge %0d, required no change", level, cyc);
          end else begin
            e = lq.pop_front();
            if (int'(level) != e.val || cyc != e.cyc) begin
              fails++;
              $display("FAIL level_event: got level=%0d at edge %0d, required level=%0d at edge %0d", level, cyc, e.val, e.cyc);
            end
          end
        end
        if (done === 1'b1) begin
          checks++;
          if (dq.size() == 0) begin
            fails++;
            $display("FAIL done_event: got done=1 at edge %0d, required no pulse", cyc);
          end else begin
            e = dq.pop_front();
            if (cyc != e.cyc) begin
              fails++;
              $display("FAIL done_event: got done pulse at edge %0d, required at edge %0d", cyc, e.cyc);
            end
          end
        end
      end
      prev = level;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic push_ramp(input int from, input int to, input int start, input int r, input bit with_done);
    int v = from, k = 0;
    while (v != to) begin
      v = (to > v) ? v + 1 : v - 1;
      k++;
      lq.push_back('{start + k * r, v});
    end
    if (with_done) dq.push_back('{start + k * r, 0});
  endtask

  task automatic load_op(input int t, input int r, input bit b, input int exp_busy);
    target = 8'(t);
    rate = 16'(r);
    breathe = b;
    load = 1;
    @(negedge clock);
    load = 0;
    chk("busy_after_load", int'(busy), exp_busy);
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc < c && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("wait_reached", int'(cyc >= c), 1);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((lq.size() != 0 || dq.size() != 0) && n < bound) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    chk("queues_empty", lq.size() + dq.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_level", int'(level), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 0;
    @(negedge clock);
    e0 = cyc + 1;
    load_op(200, 1, 0, 1);
    wait_cyc(e0 + 50);
    chk("midramp_level", int'(level), 50);
    #2 reset = 1;
    #1;
    chk("async_reset_level", int'(level), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    mon_en = 1;
    e0 = cyc + 1;
    push_ramp(0, 4, e0, 3, 1);
    load_op(4, 3, 0, 1);
    drain(100);
    chk("ramp_up_busy_end", int'(busy), 0);
    e0 = cyc + 1;
    push_ramp(4, 1, e0, 1, 1);
    load_op(1, 0, 0, 1);
    drain(100);
    e0 = cyc + 1;
    push_ramp(1, 10, e0, 1, 1);
    load_op(10, 1, 0, 1);
    drain(100);
    e0 = cyc + 1;
    dq.push_back('{e0, 0});
    load_op(10, 1, 0, 0);
    drain(10);
    chk("equal_level", int'(level), 10);
    chk("equal_busy", int'(busy), 0);
    e0 = cyc + 1;
    push_ramp(10, 40, e0, 1, 0);
    load_op(100, 1, 0, 1);
    wait_cyc(e0 + 30);
    e0 = cyc + 1;
    push_ramp(40, 20, e0, 1, 1);
    load_op(20, 1, 0, 1);
    drain(100);
    e0 = cyc + 1;
    push_ramp(20, 0, e0, 1, 1);
    load_op(0, 1, 0, 1);
    drain(100);
    e0 = cyc + 1;
    push_ramp(0, 3, e0, 2, 0);
    push_ramp(3, 0, e0 + 6, 2, 0);
    push_ramp(0, 2, e0 + 12, 2, 0);
    lq.push_back('{e0 + 18, 3});
    dq.push_back('{e0 + 18, 0});
    load_op(3, 2, 1, 1);
    wait_cyc(e0 + 16);
    chk("breathe_mid_level", int'(level), 2);
    breathe = 0;
    drain(100);
    chk("breathe_exit_busy", int'(busy), 0);
    e0 = cyc + 1;
    push_ramp(3, 0, e0, 2, 0);
    load_op(0, 2, 1, 1);
    repeat (30) @(negedge clock);
    chk("zero_peak_level", int'(level), 0);
    chk("zero_peak_busy", int'(busy), 1);
    chk("zero_peak_queues", lq.size() + dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1);
  end
endmodule
